// File: rtl/riscv_div_ctrl_pkg.sv
// Shared definitions for the divider issue/writeback controller: FSM encoding,
// timeout default and the RV32M divide/remainder decode masks.
package riscv_div_ctrl_pkg;

    localparam int unsigned TIMEOUT_DEFAULT = 40;
    localparam int unsigned CNT_W           = 6;

    localparam logic [31:0] INST_DIV       = 32'h0200_4033;
    localparam logic [31:0] INST_DIV_MASK  = 32'hfe00_707f;
    localparam logic [31:0] INST_DIVU      = 32'h0200_5033;
    localparam logic [31:0] INST_DIVU_MASK = 32'hfe00_707f;
    localparam logic [31:0] INST_REM       = 32'h0200_6033;
    localparam logic [31:0] INST_REM_MASK  = 32'hfe00_707f;
    localparam logic [31:0] INST_REMU      = 32'h0200_7033;
    localparam logic [31:0] INST_REMU_MASK = 32'hfe00_707f;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WB    = 3'd3,
        ST_DRAIN = 3'd4
    } div_state_e;

    function automatic logic is_div_op(input logic [31:0] op);
        return ((op & INST_DIV_MASK)  == INST_DIV)  ||
               ((op & INST_DIVU_MASK) == INST_DIVU) ||
               ((op & INST_REM_MASK)  == INST_REM)  ||
               ((op & INST_REMU_MASK) == INST_REMU);
    endfunction

endpackage

// File: rtl/riscv_div_ctrl_if.sv
// Bundle of the execute-stage issue port, divider handshake and writeback port.
// The slave view belongs to the controller; the master view to its surroundings.
interface riscv_div_ctrl_if;
    logic        flush;
    logic        issue_valid;
    logic [31:0] issue_opcode;
    logic [31:0] issue_ra;
    logic [31:0] issue_rb;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        stall;
    logic        div_valid;
    logic [31:0] div_opcode;
    logic [31:0] div_ra;
    logic [31:0] div_rb;
    logic        div_done;
    logic [31:0] div_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    modport slave (
        input  flush, issue_valid, issue_opcode, issue_ra, issue_rb, issue_rd,
               div_done, div_result,
        output issue_ready, stall, div_valid, div_opcode, div_ra, div_rb,
               wb_valid, wb_rd, wb_data, timeout_err
    );

    modport master (
        output flush, issue_valid, issue_opcode, issue_ra, issue_rb, issue_rd,
               div_done, div_result,
        input  issue_ready, stall, div_valid, div_opcode, div_ra, div_rb,
               wb_valid, wb_rd, wb_data, timeout_err
    );
endinterface

// File: rtl/riscv_div_ctrl.sv
// Issue/writeback controller for the iterative divider. All outputs are registered
// from the next state, so nothing from div_done reaches wb_valid combinationally.
module riscv_div_ctrl
    import riscv_div_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                srst,
    riscv_div_ctrl_if.slave     bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_inc;
    logic              accept;

    logic              issue_ready_q, stall_q, div_valid_q, wb_valid_q, timeout_q;
    logic [31:0]       opcode_q, ra_q, rb_q, wb_data_q;
    logic [4:0]        wb_rd_q;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.issue_valid && !bus.flush && is_div_op(bus.issue_opcode)
                    && (bus.issue_rd != 5'd0)) begin
                    accept  = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            // The divider cannot abort, so a flushed request is still launched and drained.
            ST_ISSUE: state_d = bus.flush ? ST_DRAIN : ST_WAIT;
            ST_WAIT: begin
                if (bus.flush)
                    state_d = bus.div_done ? ST_IDLE : ST_DRAIN;
                else if (bus.div_done)
                    state_d = ST_WB;
            end
            ST_WB:    state_d = ST_IDLE;
            ST_DRAIN: if (bus.div_done) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            issue_ready_q <= 1'b1;
            stall_q       <= 1'b0;
            div_valid_q   <= 1'b0;
            wb_valid_q    <= 1'b0;
            timeout_q     <= 1'b0;
            opcode_q      <= '0;
            ra_q          <= '0;
            rb_q          <= '0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            issue_ready_q <= (state_d == ST_IDLE);
            stall_q       <= (state_d == ST_ISSUE) || (state_d == ST_WAIT) || (state_d == ST_DRAIN);
            div_valid_q   <= (state_d == ST_ISSUE);
            wb_valid_q    <= (state_d == ST_WB);

            if (accept) begin
                opcode_q <= bus.issue_opcode;
                ra_q     <= bus.issue_ra;
                rb_q     <= bus.issue_rb;
                wb_rd_q  <= bus.issue_rd;
                cnt_q    <= '0;
            end

            if (state_q == ST_WAIT) begin
                cnt_q <= cnt_inc;
                if (cnt_inc >= TIMEOUT_CNT)
                    timeout_q <= 1'b1;
                if (bus.div_done && !bus.flush)
                    wb_data_q <= bus.div_result;
            end
        end
    end

    assign bus.issue_ready = issue_ready_q;
    assign bus.stall       = stall_q;
    assign bus.div_valid   = div_valid_q;
    assign bus.div_opcode  = opcode_q;
    assign bus.div_ra      = ra_q;
    assign bus.div_rb      = rb_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = wb_rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_riscv_div_ctrl.sv
// Directed bench for riscv_div_ctrl with a behavioural divider stub of adjustable latency.
// Inputs are driven and outputs sampled on the falling edge.
module tb_riscv_div_ctrl;

    localparam logic [31:0] OP_DIV  = 32'h0200_4033;
    localparam logic [31:0] OP_DIVU = 32'h0200_5033;
    localparam logic [31:0] OP_REM  = 32'h0200_6033;
    localparam logic [31:0] OP_REMU = 32'h0200_7033;
    localparam logic [31:0] OP_ADD  = 32'h0000_0033;
    localparam logic [31:0] OP_MUL  = 32'h0200_0033;
    localparam logic [137:0] RST_OUT = {1'b1, 137'd0};

    logic clk = 1'b0;
    logic srst = 1'b1;
    always #5 clk = ~clk;

    riscv_div_ctrl_if ifc ();

    riscv_div_ctrl #(.TIMEOUT(40)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit          stub_en  = 1'b1;
    int          stub_lat = 2;
    int          stub_cnt = 0;
    logic [31:0] stub_res = '0;

    function automatic logic [31:0] div_model(input logic [31:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [31:0] sa, sb;
        logic [31:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (op[14:12])
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF :
                      ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) ? a : 32'(sa / sb);
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a :
                      ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) ? 32'd0 : 32'(sa % sb);
            3'd7: r = (b == 0) ? a : a % b;
            default: r = 32'hDEAD_0000;
        endcase
        return r;
    endfunction

    function automatic logic [137:0] pack_out();
        return {ifc.issue_ready, ifc.stall, ifc.div_valid, ifc.div_opcode, ifc.div_ra,
                ifc.div_rb, ifc.wb_valid, ifc.wb_rd, ifc.wb_data, ifc.timeout_err};
    endfunction

    // Divider stub: answers stub_lat cycles after it sees div_valid.
    initial begin
        ifc.div_done   = 1'b0;
        ifc.div_result = 32'hDEAD_BEEF;
        forever begin
            @(negedge clk);
            ifc.div_done   = 1'b0;
            ifc.div_result = 32'hDEAD_BEEF;
            if (srst) begin
                stub_cnt = 0;
            end else begin
                if (stub_cnt > 0) begin
                    stub_cnt--;
                    if (stub_cnt == 0) begin
                        ifc.div_done   = 1'b1;
                        ifc.div_result = stub_res;
                    end
                end
                if (ifc.div_valid && stub_en) begin
                    stub_res = div_model(ifc.div_opcode, ifc.div_ra, ifc.div_rb);
                    stub_cnt = stub_lat;
                end
            end
        end
    end

    task automatic drive_issue(input logic [31:0] op, input logic [31:0] ra,
                               input logic [31:0] rb, input logic [4:0] rd,
                               output int wait_cyc);
        wait_cyc = 0;
        while (!ifc.issue_ready && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
        end
        ifc.issue_valid  = 1'b1;
        ifc.issue_opcode = op;
        ifc.issue_ra     = ra;
        ifc.issue_rb     = rb;
        ifc.issue_rd     = rd;
        @(negedge clk);
        ifc.issue_valid  = 1'b0;
    endtask

    task automatic run_to_wb(output bit got_wb, output int dv_pulses, output bit done_prev,
                             output bit stall_drop);
        bit prev;
        prev = 1'b0;
        got_wb = 1'b0; dv_pulses = 0; done_prev = 1'b0; stall_drop = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ifc.div_valid) dv_pulses++;
            if (ifc.wb_valid) begin
                got_wb    = 1'b1;
                done_prev = prev;
                break;
            end
            if (!ifc.stall) stall_drop = 1'b1;
            prev = ifc.div_done;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (pack_out() !== RST_OUT) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected %h", pack_out(), RST_OUT);
        end
        srst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_div_signed();
        int w, dv; bit got, dprev, sdrop;
        stub_lat = 2;
        drive_issue(OP_DIV, 32'd100, 32'd7, 5'd5, w);
        n_cmp++;
        if ({ifc.div_valid, ifc.stall, ifc.issue_ready} !== 3'b110) begin
            n_bad++;
            $display("FAIL div_issue_cycle: got valid/stall/ready=%b expected 110",
                     {ifc.div_valid, ifc.stall, ifc.issue_ready});
        end
        n_cmp++;
        if ({ifc.div_opcode, ifc.div_ra, ifc.div_rb} !== {OP_DIV, 32'd100, 32'd7}) begin
            n_bad++;
            $display("FAIL div_operands: got %h/%h/%h expected %h/00000064/00000007",
                     ifc.div_opcode, ifc.div_ra, ifc.div_rb, OP_DIV);
        end
        run_to_wb(got, dv, dprev, sdrop);
        n_cmp++;
        if ({got, dprev, sdrop} !== 3'b110 || dv !== 1) begin
            n_bad++;
            $display("FAIL div_sequence: got wb=%0d done_prev=%0d stall_drop=%0d pulses=%0d expected 1 1 0 1",
                     got, dprev, sdrop, dv);
        end
        n_cmp++;
        if (ifc.wb_rd !== 5'd5 || ifc.wb_data !== 32'd14) begin
            n_bad++;
            $display("FAIL div_result: got rd=%0d data=%h expected rd=5 data=0000000e",
                     ifc.wb_rd, ifc.wb_data);
        end
        @(negedge clk);
        n_cmp++;
        if ({ifc.stall, ifc.wb_valid, ifc.issue_ready} !== 3'b001) begin
            n_bad++;
            $display("FAIL div_after_wb: got stall/wb/ready=%b expected 001",
                     {ifc.stall, ifc.wb_valid, ifc.issue_ready});
        end
    endtask

    task automatic test_rem_negative();
        int w, dv; bit got, dprev, sdrop;
        drive_issue(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, w);
        run_to_wb(got, dv, dprev, sdrop);
        n_cmp++;
        if (!got || ifc.wb_rd !== 5'd7 || ifc.wb_data !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL rem_negative: got wb=%0d rd=%0d data=%h expected 1 7 ffffffff",
                     got, ifc.wb_rd, ifc.wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_divu_zero();
        int w, dv; bit got, dprev, sdrop;
        drive_issue(OP_DIVU, 32'h1234_5678, 32'd0, 5'd31, w);
        run_to_wb(got, dv, dprev, sdrop);
        n_cmp++;
        if (!got || ifc.wb_rd !== 5'd31 || ifc.wb_data !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL divu_zero: got wb=%0d rd=%0d data=%h expected 1 31 ffffffff",
                     got, ifc.wb_rd, ifc.wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_drop();
        logic [31:0] ops [4] = '{OP_ADD, OP_DIV, OP_MUL, OP_DIV};
        logic [4:0]  rds [4] = '{5'd5, 5'd0, 5'd5, 5'd5};
        logic        fls [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int v = 0; v < 4; v++) begin
            int dv, wb, nr;
            dv = 0; wb = 0; nr = 0;
            ifc.issue_valid  = 1'b1;
            ifc.issue_opcode = ops[v];
            ifc.issue_ra     = 32'd40;
            ifc.issue_rb     = 32'd4;
            ifc.issue_rd     = rds[v];
            ifc.flush        = fls[v];
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (ifc.div_valid) dv++;
                if (ifc.wb_valid) wb++;
                if (!ifc.issue_ready) nr++;
            end
            ifc.issue_valid = 1'b0;
            ifc.flush       = 1'b0;
            n_cmp++;
            if (dv !== 0 || wb !== 0 || nr !== 0) begin
                n_bad++;
                $display("FAIL drop_%0d: got div_valid=%0d wb_valid=%0d not_ready=%0d cycles expected 0 0 0",
                         v, dv, wb, nr);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_flush_wait();
        int w, dv; bit got, dprev, sdrop;
        bit wb_seen, done_seen, stall_at_done, stall_low;
        wb_seen = 0; done_seen = 0; stall_at_done = 0; stall_low = 0;
        stub_lat = 11;
        drive_issue(OP_DIV, 32'd50, 32'd5, 5'd3, w);
        @(negedge clk);
        ifc.flush = 1'b1;
        @(negedge clk);
        ifc.flush = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ifc.wb_valid) wb_seen = 1'b1;
            if (ifc.div_done) begin
                done_seen     = 1'b1;
                stall_at_done = ifc.stall;
                break;
            end
            if (!ifc.stall) stall_low = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        if (ifc.wb_valid) wb_seen = 1'b1;
        n_cmp++;
        if ({wb_seen, done_seen, stall_at_done, stall_low} !== 4'b0110) begin
            n_bad++;
            $display("FAIL flush_wait_drain: got wb/done/stall_at_done/stall_low=%b expected 0110",
                     {wb_seen, done_seen, stall_at_done, stall_low});
        end
        n_cmp++;
        if ({ifc.stall, ifc.issue_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL flush_wait_release: got stall/ready=%b expected 01",
                     {ifc.stall, ifc.issue_ready});
        end
        stub_lat = 2;
        drive_issue(OP_DIVU, 32'd9, 32'd3, 5'd9, w);
        run_to_wb(got, dv, dprev, sdrop);
        n_cmp++;
        if (!got || ifc.wb_rd !== 5'd9 || ifc.wb_data !== 32'd3) begin
            n_bad++;
            $display("FAIL flush_wait_next: got wb=%0d rd=%0d data=%h expected 1 9 00000003",
                     got, ifc.wb_rd, ifc.wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_flush_issue();
        int w; bit wb_seen, done_seen;
        wb_seen = 0; done_seen = 0;
        stub_lat = 3;
        drive_issue(OP_DIV, 32'd8, 32'd2, 5'd4, w);
        ifc.flush = 1'b1;
        n_cmp++;
        if (ifc.div_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_issue_pulse: got div_valid=%b expected 1", ifc.div_valid);
        end
        @(negedge clk);
        ifc.flush = 1'b0;
        n_cmp++;
        if ({ifc.div_valid, ifc.stall} !== 2'b01) begin
            n_bad++;
            $display("FAIL flush_issue_drain: got div_valid/stall=%b expected 01",
                     {ifc.div_valid, ifc.stall});
        end
        for (int i = 0; i < 20; i++) begin
            if (ifc.wb_valid) wb_seen = 1'b1;
            if (ifc.div_done) begin done_seen = 1'b1; break; end
            @(negedge clk);
        end
        repeat (2) begin
            @(negedge clk);
            if (ifc.wb_valid) wb_seen = 1'b1;
        end
        n_cmp++;
        if ({wb_seen, done_seen, ifc.issue_ready, ifc.stall} !== 4'b0110) begin
            n_bad++;
            $display("FAIL flush_issue_end: got wb/done/ready/stall=%b expected 0110",
                     {wb_seen, done_seen, ifc.issue_ready, ifc.stall});
        end
    endtask

    task automatic test_flush_done_same();
        int w; bit wb_seen;
        wb_seen = 0;
        stub_lat = 3;
        drive_issue(OP_DIV, 32'd9, 32'd3, 5'd6, w);
        repeat (3) @(negedge clk);
        ifc.flush = 1'b1;
        @(negedge clk);
        ifc.flush = 1'b0;
        n_cmp++;
        if ({ifc.issue_ready, ifc.stall, ifc.wb_valid} !== 3'b100) begin
            n_bad++;
            $display("FAIL flush_done_same: got ready/stall/wb=%b expected 100",
                     {ifc.issue_ready, ifc.stall, ifc.wb_valid});
        end
        repeat (3) begin
            @(negedge clk);
            if (ifc.wb_valid) wb_seen = 1'b1;
        end
        n_cmp++;
        if (wb_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_done_no_wb: got wb_valid seen=%0d expected 0", wb_seen);
        end
    endtask

    task automatic test_back_to_back();
        int w, dv; bit got, dprev, sdrop;
        stub_lat = 2;
        drive_issue(OP_REMU, 32'd17, 32'd5, 5'd10, w);
        run_to_wb(got, dv, dprev, sdrop);
        n_cmp++;
        if (!got || ifc.wb_rd !== 5'd10 || ifc.wb_data !== 32'd2) begin
            n_bad++;
            $display("FAIL b2b_first: got wb=%0d rd=%0d data=%h expected 1 10 00000002",
                     got, ifc.wb_rd, ifc.wb_data);
        end
        drive_issue(OP_DIVU, 32'd1000, 32'd10, 5'd11, w);
        n_cmp++;
        if (w !== 1 || ifc.div_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_accept: got wait=%0d div_valid=%b expected 1 1", w, ifc.div_valid);
        end
        run_to_wb(got, dv, dprev, sdrop);
        n_cmp++;
        if (!got || ifc.wb_rd !== 5'd11 || ifc.wb_data !== 32'd100) begin
            n_bad++;
            $display("FAIL b2b_second: got wb=%0d rd=%0d data=%h expected 1 11 00000064",
                     got, ifc.wb_rd, ifc.wb_data);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout_srst();
        int w;
        stub_en = 1'b0;
        drive_issue(OP_DIV, 32'h1234_5678, 32'd3, 5'd12, w);
        repeat (40) @(negedge clk);
        n_cmp++;
        if ({ifc.timeout_err, ifc.stall} !== 2'b01) begin
            n_bad++;
            $display("FAIL timeout_early: got timeout/stall=%b expected 01",
                     {ifc.timeout_err, ifc.stall});
        end
        @(negedge clk);
        n_cmp++;
        if ({ifc.timeout_err, ifc.stall} !== 2'b11) begin
            n_bad++;
            $display("FAIL timeout_set: got timeout/stall=%b expected 11",
                     {ifc.timeout_err, ifc.stall});
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({ifc.timeout_err, ifc.stall, ifc.issue_ready} !== 3'b110) begin
            n_bad++;
            $display("FAIL timeout_sticky: got timeout/stall/ready=%b expected 110",
                     {ifc.timeout_err, ifc.stall, ifc.issue_ready});
        end
        srst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (pack_out() !== RST_OUT) begin
            n_bad++;
            $display("FAIL srst_in_wait: got %h expected %h", pack_out(), RST_OUT);
        end
        srst = 1'b0;
        stub_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        ifc.flush        = 1'b0;
        ifc.issue_valid  = 1'b0;
        ifc.issue_opcode = '0;
        ifc.issue_ra     = '0;
        ifc.issue_rb     = '0;
        ifc.issue_rd     = '0;
        @(negedge clk);
        test_reset();
        test_div_signed();
        test_rem_negative();
        test_divu_zero();
        test_drop();
        test_flush_wait();
        test_flush_issue();
        test_flush_done_same();
        test_back_to_back();
        test_timeout_srst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_div_ctrl.md
# riscv_div_ctrl

Issue/writeback controller that drives the core's iterative divider. It accepts one decoded DIV/DIVU/REM/REMU instruction from the execute stage and stalls the pipeline while the operation runs. It launches the divider with a single-cycle request pulse, waits for its completion pulse, and returns the result on the register-file writeback port. Flushes arriving mid-operation are drained safely, because the divider cannot abort.

## Interface
- TIMEOUT, default 40: cycles in WAIT before `timeout_err` sets; must be greater than 35, the worst-case divider latency.
- clk  in  1  clock; all state updates on its rising edge.
- srst  in  1  synchronous reset, active-high.
- flush  in  1  squash the in-flight instruction.
- issue_valid  in  1  execute stage presents a divide instruction.
- issue_opcode  in  32  raw instruction word.
- issue_ra  in  32  rs1 value.
- issue_rb  in  32  rs2 value.
- issue_rd  in  5  destination register.
- issue_ready  out  1  controller is in IDLE; reset value 1.
- stall  out  1  hold the pipeline; reset value 0.
- div_valid  out  1  one-cycle start pulse to the divider; reset value 0.
- div_opcode  out  32  opcode to the divider, registered at accept; reset value 0.
- div_ra  out  32  dividend, registered at accept; reset value 0.
- div_rb  out  32  divisor, registered at accept; reset value 0.
- div_done  in  1  divider completion pulse.
- div_result  in  32  divider result, valid while `div_done` is high.
- wb_valid  out  1  writeback strobe; reset value 0.
- wb_rd  out  5  writeback register; reset value 0.
- wb_data  out  32  writeback data; reset value 0.
- timeout_err  out  1  sticky timeout flag; reset value 0; cleared only by `srst`.

## Operation
- States: IDLE, ISSUE, WAIT, WB, DRAIN. Reset enters IDLE from any state, including mid-operation.
- **IDLE**
  - `issue_ready` = 1.
  - On `issue_valid` with `flush` = 0:
    - Decode the opcode with the shared DIV/DIVU/REM/REMU masks.
    - If the opcode is none of the four, or `issue_rd` = 0: drop the instruction. Stay in IDLE, no `div_valid`, no `wb_valid`.
    - Otherwise latch opcode, operands and rd, then go to ISSUE.
- **ISSUE**
  - `div_valid` = 1 for exactly this cycle, then go to WAIT.
  - `div_valid` must never stay high for two consecutive cycles. The divider's start path has priority over its completion path, so a held request would never complete.
  - `flush` in ISSUE: still pulse `div_valid`, then go to DRAIN.
- **WAIT**
  - The timeout counter increments each cycle.
  - On `div_done`: capture `div_result` into `wb_data`, then go to WB.
  - `flush` without `div_done`: go to DRAIN.
  - `flush` and `div_done` in the same cycle: the flush wins. Go to IDLE and do not write back.
  - When the counter reaches TIMEOUT: set `timeout_err` and remain in WAIT.
- **WB**
  - `wb_valid` = 1 for one cycle with the latched `wb_rd` and `wb_data`, then go to IDLE.
  - A `flush` in WB is ignored; the instruction has already committed.
- **DRAIN**
  - Wait for `div_done`, discard the result, then go to IDLE.
  - `flush` in DRAIN has no effect.
- **`stall`**: high in ISSUE, WAIT and DRAIN; low in IDLE and WB.
- **Arithmetic**: none here. Sign handling, divide-by-zero (quotient all-ones, remainder = dividend) and overflow results are the divider's responsibility and are passed through unchanged.
- **Timeout counter**: 6 bits, saturating; cleared on entry to ISSUE.

## Timing
- Accept at edge T, `div_valid` high in cycle T+1, WAIT from T+2.
- `wb_valid` is high in the cycle after `div_done` is sampled.
- Total latency, accept to `wb_valid` = divider latency + 3 cycles.
- Repeated identical operands and opcode: the divider answers in 2 cycles, so total latency is 5 cycles.
- Back-to-back: the earliest next accept is the cycle after WB, because `issue_ready` returns high in the IDLE cycle that follows WB.
- Outputs are registered, with no combinational path from `div_done` to `wb_valid`.

## Structure
- State encodings (3 bits) and the TIMEOUT default belong in `riscv_def.v`, alongside the existing INST_DIV/DIVU/REM/REMU mask constants.
- The opcode decode reuses those constants.
- No sub-module: one FSM, one operand register set and one counter.

## Test plan
- **DIV signed**: `ra` = 100, `rb` = 7, rd = 5. Expect one `div_valid` pulse, then `wb_valid` with rd = 5, data = 14; `stall` low afterwards.
- **REM negative**: `ra` = 0xFFFFFFF9 (−7), `rb` = 2. Expect `wb_data` = 0xFFFFFFFF (−1).
- **DIVU by zero**: `ra` = 0x12345678, `rb` = 0. Expect `wb_data` = 0xFFFFFFFF.
- **rd = 0, or a non-divide opcode** (e.g. ADD 0x00000033). Expect no `div_valid`, no `wb_valid`, `issue_ready` continuously 1.
- **Flush in WAIT**: then `div_done` arrives 10 cycles later. Expect no `wb_valid`, `stall` deasserts after `div_done`, and the next instruction (e.g. DIVU 9/3) writes back 3.
- **Reset and timeout**:
  - `srst` in WAIT: all outputs return to their reset values in the next cycle.
  - A divider stub that never asserts `div_done`: `timeout_err` = 1 after 40 WAIT cycles and `stall` stays 1.
